// File: rtl/pong_game_ctrl.sv
// Per-frame Pong game sequencer: ball motion, paddles, speed-up, scoring and serve/over flow.
// Optional macro AUTO_P2_EN makes the right paddle track the ball instead of p2_up/p2_dn.
module pong_game_ctrl #(
  parameter int TOP_MARGIN       = 25,
  parameter int PADDLE_STEP      = 4,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int WIN_SCORE        = 5,
  parameter int SERVE_FRAMES     = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [3:0] ball_speed,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_e;

  localparam logic [9:0]  CENTRE_X     = 10'd316;
  localparam logic [9:0]  CENTRE_Y     = 10'd248;
  localparam logic [9:0]  PADDLE_RESET = 10'd191;
  localparam logic [9:0]  PADDLE_MAX   = 10'd382;
  localparam logic [9:0]  STEP10       = 10'(PADDLE_STEP);
  localparam logic [10:0] TOP_Y        = 11'(TOP_MARGIN);
  localparam logic [10:0] BOTTOM_Y     = 11'd472;
  localparam logic [10:0] LEFT_FACE    = 11'd41;
  localparam logic [10:0] RIGHT_FACE   = 11'd592;
  localparam logic [3:0]  SPEED_MIN    = 4'd2;
  localparam logic [3:0]  SPEED_MAX    = 4'd5;
  localparam logic [3:0]  WIN          = 4'(WIN_SCORE);
  localparam logic [7:0]  SERVE_LAST   = 8'(SERVE_FRAMES - 1);
  localparam logic [2:0]  HIT_LAST     = 3'(HITS_PER_SPEEDUP - 1);

  state_e      state_q, state_d;
  logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [9:0]  paddle1_q, paddle1_d, paddle2_q, paddle2_d;
  logic [3:0]  speed_q, speed_d, score1_q, score1_d, score2_q, score2_d;
  logic [2:0]  hit_cnt_q, hit_cnt_d;
  logic [7:0]  serve_cnt_q, serve_cnt_d;
  logic        dx_right_q, dx_right_d, dy_down_q, dy_down_d;
  logic        game_over_q, game_over_d;

  logic [10:0] bx_w, by_w, spd_w, p1_top, p2_top;
  logic        overlap1, overlap2, p2_move_up, p2_move_dn;
  logic        hit, left_lost, right_lost;

  // Up wins only when pressed alone; both or neither leaves the paddle where it is.
  function automatic logic [9:0] step_paddle(input logic [9:0] y, input logic up, input logic dn);
    if (up && !dn) return (y < STEP10) ? 10'd0 : y - STEP10;
    if (dn && !up) return (y >= PADDLE_MAX - STEP10) ? PADDLE_MAX : y + STEP10;
    return y;
  endfunction

  assign bx_w   = {1'b0, ball_x_q};
  assign by_w   = {1'b0, ball_y_q};
  assign spd_w  = {7'd0, speed_q};
  assign p1_top = {1'b0, paddle1_q} + TOP_Y;
  assign p2_top = {1'b0, paddle2_q} + TOP_Y;
  assign overlap1 = (by_w + 11'd7 >= p1_top) && (by_w <= p1_top + 11'd72);
  assign overlap2 = (by_w + 11'd7 >= p2_top) && (by_w <= p2_top + 11'd72);

`ifdef AUTO_P2_EN
  assign p2_move_up = ({1'b0, paddle2_q} + 11'd61) > (by_w + 11'd3);
  assign p2_move_dn = ({1'b0, paddle2_q} + 11'd61) < (by_w + 11'd3);
`else
  assign p2_move_up = p2_up;
  assign p2_move_dn = p2_dn;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ball_x_q    <= CENTRE_X;
      ball_y_q    <= CENTRE_Y;
      dx_right_q  <= 1'b1;
      dy_down_q   <= 1'b1;
      paddle1_q   <= PADDLE_RESET;
      paddle2_q   <= PADDLE_RESET;
      speed_q     <= SPEED_MIN;
      hit_cnt_q   <= 3'd0;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      serve_cnt_q <= 8'd0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_right_q  <= dx_right_d;
      dy_down_q   <= dy_down_d;
      paddle1_q   <= paddle1_d;
      paddle2_q   <= paddle2_d;
      speed_q     <= speed_d;
      hit_cnt_q   <= hit_cnt_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      serve_cnt_q <= serve_cnt_d;
      game_over_q <= game_over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_right_d  = dx_right_q;
    dy_down_d   = dy_down_q;
    paddle1_d   = paddle1_q;
    paddle2_d   = paddle2_q;
    speed_d     = speed_q;
    hit_cnt_d   = hit_cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    serve_cnt_d = serve_cnt_q;
    hit         = 1'b0;
    left_lost   = 1'b0;
    right_lost  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SERVE;
          serve_cnt_d = 8'd0;
          score1_d    = 4'd0;
          score2_d    = 4'd0;
        end
      end

      SERVE: begin
        if (frame_tick) begin
          paddle1_d   = step_paddle(paddle1_q, p1_up, p1_dn);
          paddle2_d   = step_paddle(paddle2_q, p2_move_up, p2_move_dn);
          serve_cnt_d = serve_cnt_q + 8'd1;
          if (serve_cnt_q == SERVE_LAST) state_d = PLAY;
        end
      end

      PLAY: begin
        if (frame_tick) begin
          paddle1_d = step_paddle(paddle1_q, p1_up, p1_dn);
          paddle2_d = step_paddle(paddle2_q, p2_move_up, p2_move_dn);

          if (dy_down_q) begin
            if (by_w + spd_w >= BOTTOM_Y) begin
              ball_y_d  = BOTTOM_Y[9:0];
              dy_down_d = 1'b0;
            end else begin
              ball_y_d = ball_y_q + {6'd0, speed_q};
            end
          end else if (by_w <= TOP_Y + spd_w) begin
            ball_y_d  = TOP_Y[9:0];
            dy_down_d = 1'b1;
          end else begin
            ball_y_d = ball_y_q - {6'd0, speed_q};
          end

          // Horizontal: reaching a paddle face is either a bounce or a point for the other side.
          if (!dx_right_q) begin
            if (bx_w < LEFT_FACE + spd_w) begin
              if (overlap1) begin
                ball_x_d   = LEFT_FACE[9:0];
                dx_right_d = 1'b1;
                hit        = 1'b1;
              end else begin
                left_lost = 1'b1;
              end
            end else begin
              ball_x_d = ball_x_q - {6'd0, speed_q};
            end
          end else if (bx_w + spd_w > RIGHT_FACE) begin
            if (overlap2) begin
              ball_x_d   = RIGHT_FACE[9:0];
              dx_right_d = 1'b0;
              hit        = 1'b1;
            end else begin
              right_lost = 1'b1;
            end
          end else begin
            ball_x_d = ball_x_q + {6'd0, speed_q};
          end

          if (hit) begin
            if (hit_cnt_q == HIT_LAST) begin
              hit_cnt_d = 3'd0;
              speed_d   = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 4'd1;
            end else begin
              hit_cnt_d = hit_cnt_q + 3'd1;
            end
          end

          // The next serve heads toward whoever just conceded.
          if (left_lost || right_lost) begin
            if (left_lost) score2_d = score2_q + 4'd1;
            else           score1_d = score1_q + 4'd1;
            dx_right_d  = right_lost;
            state_d     = (score1_d == WIN || score2_d == WIN) ? OVER : SERVE;
            serve_cnt_d = 8'd0;
            ball_x_d    = CENTRE_X;
            ball_y_d    = CENTRE_Y;
            speed_d     = SPEED_MIN;
            hit_cnt_d   = 3'd0;
          end
        end
      end

      OVER: begin
        if (start) begin
          state_d     = SERVE;
          serve_cnt_d = 8'd0;
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          paddle1_d   = PADDLE_RESET;
          paddle2_d   = PADDLE_RESET;
          ball_x_d    = CENTRE_X;
          ball_y_d    = CENTRE_Y;
          speed_d     = SPEED_MIN;
          hit_cnt_d   = 3'd0;
        end
      end

      default: state_d = IDLE;
    endcase

    game_over_d = (state_d == OVER);
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign paddle1_y  = paddle1_q;
  assign paddle2_y  = paddle2_q;
  assign ball_speed = speed_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign game_over  = game_over_q;
  assign state      = state_q;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-state sequencer for the Pong display path. Runs once per video frame and owns ball position, ball direction, paddle positions, ball speed, scores and game-over. Its registered outputs drive the pixel generator's ball_x/ball_y, paddle1_y/paddle2_y, ball_speed and game_over inputs directly. Uses the pixel generator's geometry: walls at x<32 and x>608, paddles at x 32..40 and 600..608 with 73-row height, 8x8 ball, 25-row header.

Parameters:
TOP_MARGIN, 25, header height; playfield rows are 25..479
PADDLE_STEP, 4, paddle pixels moved per frame
HITS_PER_SPEEDUP, 4, paddle hits per ball-speed increment
WIN_SCORE, 5, score that ends the game
SERVE_FRAMES, 60, frames the ball is held at centre before play

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame, after the visible area
start  in  1  level; starts or restarts the game
p1_up, p1_dn  in  1 each  left paddle buttons
p2_up, p2_dn  in  1 each  right paddle buttons
ball_x, ball_y  out  10 each  ball top-left, absolute screen coordinates
paddle1_y, paddle2_y  out  10 each  paddle top, relative to TOP_MARGIN
ball_speed  out  4  pixels per frame per axis, 2..5
score1, score2  out  4 each  player scores
game_over  out  1  high in OVER state
state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3

Behaviour:
- One clock, synchronous active-high reset. All outputs are registered. Updates caused by frame_tick appear one cycle after the tick. Cycles without frame_tick hold every register, except for the state transitions listed below.
- Reset values: ball_x=316, ball_y=248, dx=right, dy=down, paddle1_y=paddle2_y=191, ball_speed=2, hit_cnt=0, scores=0, game_over=0, state=IDLE, serve_cnt=0. Reset asserted mid-game returns everything to these values on the next edge.
- IDLE: ball held at centre. start=1 → SERVE on that edge, with serve_cnt=0 and scores=0.
- SERVE: ball at (316,248), ball_speed=2, hit_cnt=0. Each frame_tick increments serve_cnt. The tick that makes serve_cnt reach SERVE_FRAMES moves to PLAY. The ball does not move on that tick.
- PLAY, each frame_tick, with s = ball_speed:
  - Vertical, moving down: if ball_y+s >= 472, set ball_y=472 and dy=up. Otherwise ball_y += s.
  - Vertical, moving up: if ball_y <= TOP_MARGIN+s, set ball_y=25 and dy=down. Otherwise ball_y -= s.
  - Horizontal, moving left: if ball_x < 41+s, the ball is at the left paddle.
    - Hit when ball_y+7 >= paddle1_y+25 and ball_y <= paddle1_y+97: ball_x=41, dx=right, hit event.
    - Otherwise miss: score2 += 1.
  - Horizontal, moving right: if ball_x+s > 592, the ball is at the right paddle.
    - Hit uses the same overlap test against paddle2_y: ball_x=592, dx=left, hit event.
    - Otherwise miss: score1 += 1.
  - Otherwise ball_x ±= s.
  - Compare with 11-bit arithmetic so no underflow or overflow can occur.
  - Hit event: if hit_cnt == HITS_PER_SPEEDUP-1, set hit_cnt=0 and ball_speed = min(ball_speed+1, 5). Otherwise hit_cnt += 1.
  - Miss: the scorer's score increments. If the new score equals WIN_SCORE → OVER. Otherwise → SERVE, with serve_cnt=0 and the next serve's dx pointing toward the player who conceded.
  - Vertical and horizontal updates on the same tick are independent. A corner bounce and a paddle hit may coincide.
- Paddles, on frame_tick in SERVE and PLAY only:
  - up alone: y = (y < PADDLE_STEP) ? 0 : y-PADDLE_STEP.
  - down alone: y = min(y+PADDLE_STEP, 382).
  - Both or neither pressed: hold.
- OVER: game_over=1 and all motion is frozen. start=1 → SERVE on the next edge, with scores cleared, paddles set to 191 and game_over=0.
- start is ignored in SERVE and PLAY.

Optional Feature:
AUTO_P2_EN
- Defined: p2_up and p2_dn are ignored. On each frame_tick in SERVE and PLAY, paddle2 tracks the ball with the same step and saturation as button control:
  - centre = paddle2_y+61, compared with ball_y+3.
  - Move up when centre > ball_y+3. Move down when centre < ball_y+3. Hold when equal.
- Undefined: paddle2 is driven by p2_up and p2_dn exactly like paddle1.

Test Plan:
- Reset check: assert reset for 2 cycles → ball (316,248), paddles 191, ball_speed 2, scores 0, game_over 0, state 0.
- Serve timing: start pulse, then 60 frame_ticks → state=2 after the 60th tick with the ball still at (316,248). The next tick gives (318,250).
- Top bounce: PLAY, dy up, ball_y=26, s=2 → ball_y=25 and dy=down. The following tick gives ball_y=27.
- Paddle hit and speed-up: paddle1_y=191, ball moving left at (42,240), s=2 → ball_x=41 and dx=right. Four hits → ball_speed=3. Sixteen more hits → saturates at 5.
- Miss and win: paddle1_y=0, ball moving left at (42,400) → score2 increments and state=SERVE. Repeating to score2=5 → state=3 and game_over=1. start then → scores 0 and state=1.
- Paddle saturation: hold p1_up for 60 ticks → paddle1_y=0. Hold p1_dn for 100 ticks → paddle1_y=382. With AUTO_P2_EN defined, p2 buttons have no effect and paddle2 converges so that paddle2_y+61 = ball_y+3 ±4.
